// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit.
package load_store_unit_pkg;

  // Request size encodings.
  localparam logic [1:0] LSU_SZ_BYTE = 2'b00;
  localparam logic [1:0] LSU_SZ_HALF = 2'b01;
  localparam logic [1:0] LSU_SZ_WORD = 2'b10;
  localparam logic [1:0] LSU_SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'b00,
    LSU_ACCESS = 2'b01,
    LSU_WRITE  = 2'b10,
    LSU_RESP   = 2'b11
  } lsu_state_e;

  // True when the byte offset is not naturally aligned for the size.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic res;
    res = 1'b0;
    if (size == LSU_SZ_HALF) res = off[0];
    else if (size == LSU_SZ_WORD) res = (off != 2'b00);
    return res;
  endfunction

  // Offset with the sub-alignment bits dropped for halfword and word accesses.
  function automatic logic [1:0] lsu_align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] res;
    res = off;
    if (size == LSU_SZ_HALF) res = {off[1], 1'b0};
    else if (size == LSU_SZ_WORD) res = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory word and right-aligned pipeline data.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    res = word;
    if (size == LSU_SZ_BYTE) begin
      sh  = word >> {off, 3'b000};
      res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end else if (size == LSU_SZ_HALF) begin
      sh  = word >> {off[1], 4'b0000};
      res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] new_data,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    logic [31:0] data;
    mask = 32'hFFFF_FFFF;
    data = new_data;
    if (size == LSU_SZ_BYTE) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'h0, new_data[7:0]} << {off, 3'b000};
    end else if (size == LSU_SZ_HALF) begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'h0, new_data[15:0]} << {off[1], 4'b0000};
    end
    return (old_word & ~mask) | (data & mask);
  endfunction

  // Both directions are pure lane steering.
  always_comb begin
    load_data_o  = extract_load(rdata_i, offset_i, size_i, unsigned_i);
    store_word_o = merge_store(rdata_i, wdata_i, offset_i, size_i);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word accesses over a word-wide memory,
// sub-word stores via read-modify-write. Build option LSU_MISALIGN_CHECK_EN
// rejects misaligned half/word requests; otherwise their low address bits are dropped.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 512
) (
  input  logic             CLK,
  input  logic             RST_N,
  load_store_unit_if.slave bus,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q, unsigned_q, err_q;
  logic [31:0] wdata_q, rdata_q;

  logic        accept, req_err, misaligned, out_of_range;
  logic [31:0] addr_in, load_data, store_word;

  assign accept       = bus.req_valid && bus.req_ready;
  assign out_of_range = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign addr_in    = bus.req_addr;
`else
  assign misaligned = 1'b0;
  assign addr_in    = {bus.req_addr[31:2], lsu_align_off(bus.req_size, bus.req_addr[1:0])};
`endif

  assign req_err = (bus.req_size == LSU_SZ_RSVD) || misaligned || out_of_range;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  // Next state: rejected requests skip straight to the response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE, LSU_RESP: begin
        if (accept) state_d = req_err ? LSU_RESP : LSU_ACCESS;
        else        state_d = LSU_IDLE;
      end
      LSU_ACCESS: state_d = (write_q && size_q != LSU_SZ_WORD) ? LSU_WRITE : LSU_RESP;
      LSU_WRITE:  state_d = LSU_RESP;
      default:    state_d = LSU_IDLE;
    endcase
  end

  // Outputs decoded from state; the write strobe never coincides with a read-merge cycle.
  always_comb begin
    bus.req_ready = (state_q == LSU_IDLE) || (state_q == LSU_RESP);
    bus.rsp_valid = (state_q == LSU_RESP);
    bus.rsp_err   = (state_q == LSU_RESP) && err_q;
    mem_we        = ((state_q == LSU_ACCESS) && write_q && (size_q == LSU_SZ_WORD)) ||
                    (state_q == LSU_WRITE);
  end

  // Request latch, load capture and read-modify-write merge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q     <= 32'h0;
      size_q     <= LSU_SZ_BYTE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
    end else if (accept) begin
      addr_q     <= addr_in;
      size_q     <= bus.req_size;
      write_q    <= bus.req_write;
      unsigned_q <= bus.req_unsigned;
      err_q      <= req_err;
      wdata_q    <= bus.req_wdata;
    end else if (state_q == LSU_ACCESS) begin
      if (!write_q)                   rdata_q <= load_data;
      else if (size_q != LSU_SZ_WORD) wdata_q <= store_word;
    end
  end

  lsu_lane_align u_lane_align (
    .rdata_i      (mem_rdata),
    .wdata_i      (wdata_q),
    .offset_i     (addr_q[1:0]),
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wdata     = wdata_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side companion to the word-wide data memory, which has a combinational read on `addr`/`RD` and writes on the CLK negedge when `WriteEnabled` is high.
- Sits in the MEM stage. Accepts byte, halfword and word load/store requests from the pipeline and issues word accesses to the memory.
- Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended.
- Reports misaligned, reserved-size and out-of-range requests as errors instead of accessing memory.

Parameters:
- MEM_WORDS, 512: number of 32-bit words in the data memory. A word index >= MEM_WORDS is an error.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid: request rejected, no memory write performed.
- rsp_rdata  out  32  extended load data; valid with rsp_valid on loads.
- mem_addr  out  32  word-aligned address to memory ({word_index, 2'b00}).
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Handshake: a request is accepted on a posedge with req_valid && req_ready. On acceptance, addr/size/write/unsigned/wdata are latched. Inputs are ignored when req_ready=0.
- Byte order is little-endian. Byte k = addr[1:0] occupies bits [8k+7:8k]. Halfword h = addr[1] occupies bits [16h+15:16h].
- States: IDLE, ACCESS, WRITE, RESP. req_ready = (IDLE || RESP). rsp_valid = RESP.
- IDLE or RESP with an accepted request: go to RESP with err=1 if any of the following hold, otherwise go to ACCESS with err=0:
  - req_size is 11;
  - a halfword has addr[0]=1;
  - a word has addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- RESP with no request goes to IDLE.
- ACCESS drives mem_addr from the latched address.
  - Load: capture the extended lane of mem_rdata into rsp_rdata, go to RESP.
  - Word store: mem_we=1, mem_wdata=latched wdata, go to RESP.
  - Sub-word store: mem_we=0; capture mem_rdata merged with the new byte or halfword into mem_wdata; go to WRITE.
- WRITE: mem_we=1, mem_addr unchanged, go to RESP.
- Latency from the accepting edge to rsp_valid high:
  - error requests: 1 cycle;
  - loads and word stores: 2 cycles;
  - sub-word stores: 3 cycles.
- Back-to-back requests: a new request accepted in RESP produces no idle bubble.
- mem_we is high only in ACCESS (word store) or WRITE, so the memory's negedge write lands mid-cycle.
- rsp_rdata holds its last value until the next load completes. On an error or a store, rsp_rdata is unchanged.
- Reset mid-operation forces IDLE and mem_we=0 immediately. A sub-word store reset before WRITE leaves memory unmodified.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: misaligned halfword/word requests complete with rsp_err=1 as above.
- Undefined: the low address bits are silently cleared for halfword (addr[0]) and word (addr[1:0]) accesses, and the access proceeds normally. Reserved-size and out-of-range checks remain in both builds.

Decomposition:
- Shared include alongside the codebase config:
  - size encodings LSU_SZ_BYTE, LSU_SZ_HALF, LSU_SZ_WORD;
  - state encodings LSU_IDLE, LSU_ACCESS, LSU_WRITE, LSU_RESP.
- One combinational sub-module, lsu_lane_align, with two functions:
  - given word, offset, size and unsigned: extract and extend load data;
  - given old word, new data, offset and size: produce the merged store word.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> mem_we high exactly 1 cycle; load rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Preload 0x11223344 at 0x20; byte store 0xAA to 0x21 -> ACCESS then WRITE; memory word becomes 0x1122AA44; rsp_valid 3 cycles after accept.
- Signed byte load at 0x21 -> 0xFFFFFFAA. Unsigned -> 0x000000AA. Signed halfword load at 0x22 -> 0x00001122.
- Word load at 0x22 with LSU_MISALIGN_CHECK_EN -> rsp_err=1 one cycle after accept, mem_we never high. Without the macro -> returns the word at 0x20.
- Store to addr 4*MEM_WORDS and req_size=11 -> rsp_err=1; memory unchanged.
- Sub-word store, RST_N low during WRITE's predecessor (ACCESS) -> mem_we stays 0, memory unchanged, req_ready=1 after release. Back-to-back loads issued in RESP -> rsp_valid every 2 cycles.
